mem_port_arbiter: RTL and testbench

- Sequences a single-ported unified memory shared by two requesters: the instruction-fetch stage (fetch port) and the memory stage (data port).
- Grants one transaction at a time and drives the memory port.
- Returns read data and a one-cycle done pulse to the winning requester.
- Produces stall signals that the pipeline uses to hold PC, IF/ID and upstream registers while a request waits.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the fetch port and the
//   data port. One transaction at a time, round-robin on contention, a
//   one-cycle done pulse per transaction, and a sticky bus_err on timeout.
//   All state moves on the falling edge of CLK to line up with the pipeline
//   registers.
//
// Ports
//   CLK, Reset_L               clock (falling-edge active), async active-low reset
//   if_req/if_addr             fetch request and address
//   if_rdata/if_done/if_stall  fetched word, completion pulse, fetch waiting
//   d_req/d_we/d_addr/d_wdata  data request (load/store)
//   d_rdata/d_done/d_stall     load data, completion pulse, data waiting
//   mem_*                      memory-side address/data/strobes/ack
//   bus_err                    sticky timeout flag, cleared only by reset
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; arbitrate between if_req and d_req
// DBUSY | data access on the memory port, waiting for mem_ack
// IBUSY | fetch on the memory port, waiting for mem_ack
// DDONE | d_done pulse, one cycle, then IDLE
// IDONE | if_done pulse, one cycle, then IDLE

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  typedef enum logic [2:0] {IDLE, DBUSY, IBUSY, DDONE, IDONE} state_t;

  // Down-counter loaded with TIMEOUT-1 on grant; reaching zero on a BUSY
  // edge without ack means TIMEOUT busy cycles have elapsed.
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              last_d;     // 1 = data port received the last grant
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [7:0]        tmo_cnt;
  logic              tmo_tc;
  logic              grant_d;
  logic              grant_i;

  assign tmo_tc  = (tmo_cnt == 8'd0);
  // On contention the port opposite the last grant wins.
  assign grant_d = d_req & (~if_req | ~last_d);
  assign grant_i = if_req & (~d_req | last_d);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = DBUSY;
        else if (grant_i) state_nxt = IBUSY;
      end
      DBUSY:   if (mem_ack || tmo_tc) state_nxt = DDONE;
      IBUSY:   if (mem_ack || tmo_tc) state_nxt = IDONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      tmo_cnt  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      bus_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_d) begin
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            we_q    <= d_we;
            last_d  <= 1'b1;
            tmo_cnt <= TMO_LOAD;
          end else if (grant_i) begin
            addr_q  <= if_addr;
            last_d  <= 1'b0;
            tmo_cnt <= TMO_LOAD;
          end
        end
        DBUSY: begin
          if (mem_ack) begin
            if (!we_q) d_rdata <= mem_rdata;
          end else if (tmo_tc) begin
            d_rdata <= '0;
            bus_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        IBUSY: begin
          if (mem_ack) begin
            if_rdata <= mem_rdata;
          end else if (tmo_tc) begin
            if_rdata <= '0;
            bus_err  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = (state == IBUSY) | ((state == DBUSY) & ~we_q);
  assign mem_wr    = (state == DBUSY) & we_q;
  assign if_done   = (state == IDONE);
  assign d_done    = (state == DDONE);
  assign if_stall  = Reset_L & if_req & ~if_done;
  assign d_stall   = Reset_L & d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, d_done, d_stall, mem_rd, mem_wr, bus_err;

  int total = 0;
  int bad   = 0;
  int ack_delay = 1;   // ack on this BUSY cycle number; 0 = never ack
  int busy_cnt  = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  // Memory responder: counts strobe cycles, raises ack mid-cycle on the chosen one.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge CLK);
      if (mem_rd || mem_wr) begin
        busy_cnt = busy_cnt + 1;
        mem_ack  = (ack_delay != 0) && (busy_cnt == ack_delay);
      end else begin
        busy_cnt = 0;
        mem_ack  = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_start();
    @(negedge CLK); #1;
  endtask

  task automatic test_reset();
    Reset_L = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    @(posedge CLK); #1;
    total++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin bad++; $display("FAIL rst_strobe: rd=%b wr=%b want 0 0", mem_rd, mem_wr); end
    total++; if (if_stall !== 1'b0 || d_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: if=%b d=%b want 0 0", if_stall, d_stall); end
    total++; if (if_done !== 1'b0 || d_done !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL rst_flags: idone=%b ddone=%b err=%b want 0", if_done, d_done, bus_err); end
    total++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_addr !== 32'h0) begin bad++; $display("FAIL rst_data: ir=%h dr=%h ma=%h want 0", if_rdata, d_rdata, mem_addr); end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge CLK); #2;
    Reset_L = 1'b1;
  endtask

  task automatic test_fetch();
    ack_delay = 1; mem_rdata = 32'h8C010004;
    drive_start(); if_addr = 32'h100; if_req = 1'b1;
    @(posedge CLK);  // cycle 0
    total++; if (if_stall !== 1'b1 || mem_rd !== 1'b0) begin bad++; $display("FAIL fetch_c0: stall=%b rd=%b want 1 0", if_stall, mem_rd); end
    @(posedge CLK);  // cycle 1
    total++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h100) begin bad++; $display("FAIL fetch_c1: rd=%b wr=%b addr=%h want 1 0 100", mem_rd, mem_wr, mem_addr); end
    total++; if (if_stall !== 1'b1 || if_done !== 1'b0) begin bad++; $display("FAIL fetch_c1_stall: stall=%b done=%b want 1 0", if_stall, if_done); end
    @(posedge CLK);  // cycle 2
    total++; if (if_done !== 1'b1 || if_rdata !== 32'h8C010004) begin bad++; $display("FAIL fetch_done: done=%b data=%h want 1 8c010004", if_done, if_rdata); end
    total++; if (if_stall !== 1'b0 || mem_rd !== 1'b0) begin bad++; $display("FAIL fetch_c2: stall=%b rd=%b want 0 0", if_stall, mem_rd); end
    drive_start(); if_req = 1'b0;
    @(posedge CLK);  // cycle 3
    total++; if (if_done !== 1'b0) begin bad++; $display("FAIL fetch_pulse: done=%b want 0", if_done); end
  endtask

  task automatic test_both();
    ack_delay = 1; mem_rdata = 32'h1234;
    drive_start();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; if_req = 1'b1; if_addr = 32'h200;
    @(posedge CLK);  // cycle 0
    @(posedge CLK);  // cycle 1
    total++; if (mem_rd !== 1'b1 || mem_addr !== 32'h40) begin bad++; $display("FAIL both_dgrant: rd=%b addr=%h want 1 40", mem_rd, mem_addr); end
    @(posedge CLK);  // cycle 2
    total++; if (d_done !== 1'b1 || d_rdata !== 32'h1234 || if_stall !== 1'b1) begin bad++; $display("FAIL both_ddone: done=%b data=%h istall=%b want 1 1234 1", d_done, d_rdata, if_stall); end
    drive_start(); d_req = 1'b0; mem_rdata = 32'h5678;
    @(posedge CLK);  // cycle 3
    total++; if (mem_rd !== 1'b0 || if_done !== 1'b0) begin bad++; $display("FAIL both_c3: rd=%b idone=%b want 0 0", mem_rd, if_done); end
    @(posedge CLK);  // cycle 4
    total++; if (mem_rd !== 1'b1 || mem_addr !== 32'h200) begin bad++; $display("FAIL both_igrant: rd=%b addr=%h want 1 200", mem_rd, mem_addr); end
    @(posedge CLK);  // cycle 5
    total++; if (if_done !== 1'b1 || if_rdata !== 32'h5678) begin bad++; $display("FAIL both_idone: done=%b data=%h want 1 5678", if_done, if_rdata); end
    drive_start(); if_req = 1'b0;
  endtask

  task automatic test_store();
    ack_delay = 3; mem_rdata = 32'hDEADBEEF;
    drive_start();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D;
    @(posedge CLK);  // cycle 0
    drive_start(); d_addr = 32'hFFF; d_wdata = 32'h0; d_we = 1'b0;  // ignored while busy
    for (int c = 1; c <= 3; c++) begin
      @(posedge CLK);
      total++;
      if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 32'h80 || mem_wdata !== 32'hCAFEF00D || d_done !== 1'b0) begin
        bad++; $display("FAIL store_busy c%0d: wr=%b rd=%b addr=%h wdata=%h done=%b want 1 0 80 cafef00d 0", c, mem_wr, mem_rd, mem_addr, mem_wdata, d_done);
      end
    end
    @(posedge CLK);  // cycle 4
    total++; if (d_done !== 1'b1 || d_rdata !== 32'h1234 || mem_wr !== 1'b0) begin bad++; $display("FAIL store_done: done=%b rdata=%h wr=%b want 1 1234 0", d_done, d_rdata, mem_wr); end
    drive_start(); d_req = 1'b0;
    @(posedge CLK);  // cycle 5
    total++; if (d_done !== 1'b0) begin bad++; $display("FAIL store_pulse: done=%b want 0", d_done); end
  endtask

  task automatic test_timeout();
    ack_delay = 0; mem_rdata = 32'h11111111;
    drive_start(); if_req = 1'b1; if_addr = 32'h300;
    @(posedge CLK);  // cycle 0
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK);
      total++;
      if (mem_rd !== 1'b1 || if_done !== 1'b0 || bus_err !== 1'b0) begin
        bad++; $display("FAIL tmo_busy c%0d: rd=%b done=%b err=%b want 1 0 0", c, mem_rd, if_done, bus_err);
      end
    end
    @(posedge CLK);  // cycle 5
    total++; if (if_done !== 1'b1 || if_rdata !== 32'h0 || bus_err !== 1'b1) begin bad++; $display("FAIL tmo_done: done=%b data=%h err=%b want 1 0 1", if_done, if_rdata, bus_err); end
    drive_start(); if_req = 1'b0;
    // Successful fetch afterwards leaves the flag set.
    ack_delay = 1; mem_rdata = 32'h600DF00D;
    drive_start(); if_req = 1'b1; if_addr = 32'h304;
    @(posedge CLK); @(posedge CLK); @(posedge CLK);
    total++; if (if_done !== 1'b1 || if_rdata !== 32'h600DF00D || bus_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: done=%b data=%h err=%b want 1 600df00d 1", if_done, if_rdata, bus_err); end
    drive_start(); if_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    ack_delay = 0; mem_rdata = 32'hABCD;
    drive_start(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    @(posedge CLK);  // cycle 0
    @(posedge CLK);  // cycle 1, DBUSY
    total++; if (mem_rd !== 1'b1) begin bad++; $display("FAIL rmid_busy: rd=%b want 1", mem_rd); end
    #2 Reset_L = 1'b0;
    #1;
    total++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || d_stall !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL rmid_drop: rd=%b wr=%b stall=%b err=%b want 0", mem_rd, mem_wr, d_stall, bus_err); end
    @(posedge CLK);
    total++; if (d_done !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL rmid_hold: done=%b addr=%h want 0 0", d_done, mem_addr); end
    ack_delay = 1;
    #2 Reset_L = 1'b1;
    @(posedge CLK);  // DBUSY again after restart
    total++; if (mem_rd !== 1'b1 || mem_addr !== 32'h44 || d_stall !== 1'b1 || d_done !== 1'b0) begin bad++; $display("FAIL rmid_restart: rd=%b addr=%h stall=%b done=%b want 1 44 1 0", mem_rd, mem_addr, d_stall, d_done); end
    @(posedge CLK);
    total++; if (d_done !== 1'b1 || d_rdata !== 32'hABCD) begin bad++; $display("FAIL rmid_done: done=%b data=%h want 1 abcd", d_done, d_rdata); end
    drive_start(); d_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    ack_delay = 1; mem_rdata = 32'h77;
    drive_start(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
    @(posedge CLK);  // cycle 0
    drive_start(); if_req = 1'b1; if_addr = 32'h500;
    @(posedge CLK);  // cycle 1
    @(posedge CLK);  // cycle 2, DDONE with d_req still high
    total++; if (d_done !== 1'b1 || d_rdata !== 32'h77 || mem_rd !== 1'b0) begin bad++; $display("FAIL b2b_ddone: done=%b data=%h rd=%b want 1 77 0", d_done, d_rdata, mem_rd); end
    drive_start(); mem_rdata = 32'h88;
    @(posedge CLK);  // cycle 3, IDLE
    total++; if (mem_rd !== 1'b0 || d_done !== 1'b0 || d_stall !== 1'b1) begin bad++; $display("FAIL b2b_noregrant: rd=%b done=%b stall=%b want 0 0 1", mem_rd, d_done, d_stall); end
    @(posedge CLK);  // cycle 4, fetch wins
    total++; if (mem_rd !== 1'b1 || mem_addr !== 32'h500) begin bad++; $display("FAIL b2b_fetch: rd=%b addr=%h want 1 500", mem_rd, mem_addr); end
    @(posedge CLK);  // cycle 5
    total++; if (if_done !== 1'b1 || if_rdata !== 32'h88) begin bad++; $display("FAIL b2b_idone: done=%b data=%h want 1 88", if_done, if_rdata); end
    drive_start(); if_req = 1'b0; mem_rdata = 32'h99;
    @(posedge CLK);  // cycle 6, IDLE
    @(posedge CLK);  // cycle 7, data again
    total++; if (mem_rd !== 1'b1 || mem_addr !== 32'h48) begin bad++; $display("FAIL b2b_data2: rd=%b addr=%h want 1 48", mem_rd, mem_addr); end
    @(posedge CLK);  // cycle 8
    total++; if (d_done !== 1'b1 || d_rdata !== 32'h99) begin bad++; $display("FAIL b2b_ddone2: done=%b data=%h want 1 99", d_done, d_rdata); end
    drive_start(); d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_both();
    test_store();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
